// File: rtl/div_recoded_float64_seq.sv
// div_recoded_float64_seq
// Iterative double-precision divider on 65-bit recoded operands
// {sign, exp[11:0], fract[51:0]}. It develops one quotient bit per cycle
// with a restoring radix-2 loop, then rounds in a single cycle with IEEE-754
// rounding and exception flags.
// Ports:
//   clock, reset       : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready  : operand handshake (in_ready high only while idle)
//   a, b               : dividend and divisor, recoded
//   roundingMode       : 00 nearest-even, 01 minMag, 10 min, 11 max
//   out_valid/out_ready: result handshake (result held until accepted)
//   out                : recoded quotient
//   exceptionFlags     : {invalid, divByZero, overflow, underflow, inexact}
module div_recoded_float64_seq (
   input  logic        clock,
   input  logic        reset,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [64:0] a,
   input  logic [64:0] b,
   input  logic [1:0]  roundingMode,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [64:0] out,
   output logic [4:0]  exceptionFlags
);

   typedef enum logic [1:0] {IDLE = 2'd0, DIV = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

   // Class bits {zero, inf, nan, signaling nan} of a recoded operand.
   function automatic logic [3:0] op_class(input logic [64:0] op);
      logic special;
      special  = (op[63:62] == 2'b11);
      op_class = {(op[63:61] == 3'b000), special & ~op[61], special & op[61],
                  special & op[61] & ~op[51]};
   endfunction

   state_t             state_r;
   logic [3:0]         cls_a_s, cls_b_s, cls_a_r, cls_b_r;
   logic               sign_r;
   logic [1:0]         rm_r;
   logic signed [13:0] exp_r, exp_init_s;
   logic [52:0]        sig_a_s, sig_b_s, divisor_r;
   logic               a_lt_s, special_s;
   logic [54:0]        rem_r, rem_init_s, rem_sub_s;
   logic               rem_ge_s;
   logic [53:0]        quo_r;
   logic [5:0]         cnt_r;

   logic signed [13:0] sh_full_s, exp_rnd_s;
   logic [5:0]         sh_s;
   logic               tiny_s, rbit_s, sbit_s, lsb_s, inexact_s, up_s, carry_s;
   logic               ovf_s, unf_s, big_s;
   logic [53:0]        rnd_mask_s, stk_mask_s, sum_s;
   logic [52:0]        lsb_mask_s, kept_s;
   logic [51:0]        fract_s;
   logic [64:0]        res_s;
   logic [4:0]         flags_s;
   logic               unused_s;

   assign cls_a_s   = op_class(a);
   assign cls_b_s   = op_class(b);
   assign sig_a_s   = {~cls_a_s[3], a[51:0]};
   assign sig_b_s   = {~cls_b_s[3], b[51:0]};
   assign special_s = (|cls_a_s[3:1]) | (|cls_b_s[3:1]);

   // Pre-normalise the dividend so the first quotient bit is always 1.
   assign a_lt_s     = (sig_a_s < sig_b_s);
   assign rem_init_s = a_lt_s ? {1'b0, sig_a_s, 1'b0} : {2'b00, sig_a_s};
   assign exp_init_s = $signed({2'b00, a[63:52]}) - $signed({2'b00, b[63:52]})
                       + 14'sh800 - (a_lt_s ? 14'sd1 : 14'sd0);

   assign rem_ge_s  = (rem_r >= {2'b00, divisor_r});
   assign rem_sub_s = rem_r - {2'b00, divisor_r};

   // Leading significand bit and top shift/difference bits carry no information.
   assign unused_s = ^{rem_sub_s[54], sh_full_s[13:6], sum_s[52]};

   // Rounding, range handling and special-operand results.
   always_comb begin
      // Tiny results round at a coarser position: one bit per exponent step below 0x402.
      sh_full_s = 14'sh402 - exp_r;
      tiny_s    = (exp_r < 14'sh402);
      if (tiny_s) begin
         sh_s = sh_full_s[5:0];
      end else begin
         sh_s = 6'd0;
      end
      rnd_mask_s = 54'd1 << sh_s;
      stk_mask_s = rnd_mask_s - 54'd1;
      lsb_mask_s = 53'd1 << sh_s;
      rbit_s     = |(quo_r & rnd_mask_s);
      sbit_s     = (|(quo_r & stk_mask_s)) | (|rem_r);
      lsb_s      = |(quo_r[53:1] & lsb_mask_s);
      inexact_s  = rbit_s | sbit_s;
      case (rm_r)
         2'b00:   up_s = rbit_s & (sbit_s | lsb_s);
         2'b01:   up_s = 1'b0;
         2'b10:   up_s = sign_r & inexact_s;
         2'b11:   up_s = ~sign_r & inexact_s;
         default: up_s = 1'b0;
      endcase
      kept_s  = quo_r[53:1] & ~(lsb_mask_s - 53'd1);
      sum_s   = {1'b0, kept_s} + (up_s ? {1'b0, lsb_mask_s} : 54'd0);
      carry_s = sum_s[53];
      // A carry out means the significand rounded up to exactly 2.0.
      if (carry_s) begin
         exp_rnd_s = exp_r + 14'sd1;
         fract_s   = 52'd0;
      end else begin
         exp_rnd_s = exp_r;
         fract_s   = sum_s[51:0];
      end
      ovf_s = (exp_rnd_s >= 14'shC00);
      unf_s = tiny_s & inexact_s;
      big_s = (rm_r == 2'b00) | ((rm_r == 2'b10) & sign_r) | ((rm_r == 2'b11) & ~sign_r);

      res_s   = 65'd0;
      flags_s = 5'd0;
      if (cls_a_r[1] | cls_b_r[1]) begin
         res_s   = {sign_r, 12'hE00, {52{1'b1}}};
         flags_s = {cls_a_r[0] | cls_b_r[0], 4'b0000};
      end else if ((cls_a_r[3] & cls_b_r[3]) | (cls_a_r[2] & cls_b_r[2])) begin
         res_s   = {sign_r, 12'hE00, {52{1'b1}}};
         flags_s = 5'b10000;
      end else if (cls_a_r[2]) begin
         res_s   = {sign_r, 12'hC00, 52'd0};
         flags_s = 5'b00000;
      end else if (cls_b_r[3]) begin
         res_s   = {sign_r, 12'hC00, 52'd0};
         flags_s = 5'b01000;
      end else if (cls_a_r[3] | cls_b_r[2]) begin
         res_s   = {sign_r, 12'h000, 52'd0};
         flags_s = 5'b00000;
      end else if (exp_r < 14'sh3CE) begin
         res_s   = {sign_r, 12'h000, 52'd0};
         flags_s = 5'b00011;
      end else if (ovf_s) begin
         if (big_s) begin
            res_s = {sign_r, 12'hC00, 52'd0};
         end else begin
            res_s = {sign_r, 12'hBFF, {52{1'b1}}};
         end
         flags_s = 5'b00101;
      end else begin
         res_s   = {sign_r, exp_rnd_s[11:0], fract_s};
         flags_s = {3'b000, unf_s, inexact_s | unf_s};
      end
   end

   // Control FSM, divider iteration and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r        <= IDLE;
         in_ready       <= 1'b1;
         out_valid      <= 1'b0;
         out            <= 65'd0;
         exceptionFlags <= 5'd0;
         cls_a_r        <= 4'd0;
         cls_b_r        <= 4'd0;
         sign_r         <= 1'b0;
         rm_r           <= 2'd0;
         exp_r          <= 14'sd0;
         divisor_r      <= 53'd0;
         rem_r          <= 55'd0;
         quo_r          <= 54'd0;
         cnt_r          <= 6'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  cls_a_r   <= cls_a_s;
                  cls_b_r   <= cls_b_s;
                  sign_r    <= a[64] ^ b[64];
                  rm_r      <= roundingMode;
                  exp_r     <= exp_init_s;
                  divisor_r <= sig_b_s;
                  rem_r     <= rem_init_s;
                  quo_r     <= 54'd0;
                  cnt_r     <= 6'd0;
                  in_ready  <= 1'b0;
                  state_r   <= special_s ? ROUND : DIV;
               end
            end
            DIV: begin
               rem_r <= rem_ge_s ? {rem_sub_s[53:0], 1'b0} : {rem_r[53:0], 1'b0};
               quo_r <= {quo_r[52:0], rem_ge_s};
               cnt_r <= cnt_r + 6'd1;
               // 53 significant bits plus one guard bit.
               if (cnt_r == 6'd53) begin
                  state_r <= ROUND;
               end
            end
            ROUND: begin
               out            <= res_s;
               exceptionFlags <= flags_s;
               out_valid      <= 1'b1;
               state_r        <= DONE;
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= IDLE;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

endmodule
